// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    // Width of the slice handled by the shared ripple-carry adder each cycle.
    localparam int NIBBLE_W = 4;

    // Sequencer states. Encoding is fixed so the state can be probed externally.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Number of nibble-add cycles needed for an operand of the given width.
    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder, purely combinational: {cout,sum} = a + b + cin.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b - nibble operands; cin - carry in; sum - nibble result; cout - carry out.
module ripple_carry_adder
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    // c[i] is the carry into bit i; c[NIBBLE_W] is the carry out of the nibble.
    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple-carry adder, one nibble per cycle.
// Latency: start accepted at edge k -> done high in the cycle after edge k+NIBBLES.
// Backpressure: start is only taken in IDLE or DONE; start while busy is dropped.
// Ports: clk/rst (sync, active-high); start/a/b/cin request; busy/done status;
//        sum/cout/overflow result, held from one done pulse to the next.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam int MSB     = WIDTH - 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [WIDTH-1:0]    work_merged;

    // Steer the current nibble of each latched operand into the shared adder.
    always_comb begin : nibble_select
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    ripple_carry_adder u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Work register with this cycle's nibble already dropped in. On the last
    // nibble this is the complete sum, so the result can be published on the
    // same edge without an extra cycle.
    always_comb begin : work_insert
        work_merged = work_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                work_merged[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin : fsm_next
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        unique case (state_q)
            // DONE lasts one cycle and accepts a new request exactly like IDLE,
            // which gives back-to-back operations every NIBBLES+1 cycles.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                work_d  = work_merged;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    sum_d   = work_merged;
                    cout_d  = nib_cout;
                    // Signed overflow: operands agree in sign, result does not.
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (work_merged[MSB] != a_q[MSB]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : state_regs
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q == S_ADD);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    logic       start4 = 1'b0;
    logic       cin4   = 1'b0;
    logic [3:0] a4     = '0;
    logic [3:0] b4     = '0;
    logic [3:0] sum4;
    logic       busy4, done4, cout4, ovf4;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int lat = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph counts cycles since an accepted start: 1..N busy, N+1 done, 0 idle.
    int           ph = 0;
    logic [W-1:0] p_sum = '0, m_sum = '0;
    logic         p_cout = 1'b0, m_cout = 1'b0;
    logic         p_ovf = 1'b0, m_ovf = 1'b0;

    logic [W:0] full;
    int         sval;
    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sval = int'($signed(a)) + int'($signed(b)) + int'(cin);

    wire can_acc = (ph == 0) || (ph == N + 1);

    always @(posedge clk) begin
        if (rst) begin
            ph <= 0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
        end else begin
            if (can_acc && start) begin
                p_sum  <= full[W-1:0];
                p_cout <= full[W];
                p_ovf  <= (sval > (2**(W-1)) - 1) || (sval < -(2**(W-1)));
                ph     <= 1;
            end else if (ph == N + 1) begin
                ph <= 0;
            end else if (ph != 0) begin
                ph <= ph + 1;
            end
            if (ph == N) begin
                m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
            end
        end
    end

    // One compare process, every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, (ph >= 1 && ph <= N)});
            check("done", {31'd0, done}, {31'd0, (ph == N + 1)});
            check("sum", {16'd0, sum}, {16'd0, m_sum});
            check("cout", {31'd0, cout}, {31'd0, m_cout});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (done === 1'b1) n_done++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after op(); lat = negedges passed until done is seen.
    task automatic wait_done(input string nm);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s: no done within 20 cycles", nm);
        end
        lat = cyc;
    endtask

    task automatic run_lit(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        op(ta, tb, tc);
        wait_done(nm);
        check({nm, "_lat"}, lat, N);
        check({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({nm, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        @(negedge clk); #1;
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        // 1: first op, busy right after acceptance
        op(16'h0002, 16'h0001, 1'b0);
        check("s1_busy_c1", {31'd0, busy}, 32'd1);
        wait_done("s1");
        check("s1_lat", lat, N);
        check("s1_sum", {16'd0, sum}, 32'h0003);
        @(negedge clk); #1;

        // 2, 3: carry chain and signed overflow
        run_lit("s2a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_lit("s2b", 16'h0003, 16'h0005, 1'b1, 16'h0009, 1'b0, 1'b0);
        run_lit("s3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_lit("s3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // 4: start while busy is ignored
        d0 = n_done;
        op(16'h1234, 16'h1111, 1'b0);
        @(negedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done("s4");
        check("s4_sum", {16'd0, sum}, 32'h2345);
        repeat (8) @(negedge clk);
        #1;
        check("s4_ndone", n_done - d0, 1);

        // 5: reset mid-operation
        op(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        d0 = n_done;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("s5_sum0", {16'd0, sum}, 32'd0);
        check("s5_busy0", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        #1;
        check("s5_nodone", n_done - d0, 0);
        run_lit("s5b", 16'h1000, 16'h2000, 1'b1, 16'h3001, 1'b0, 1'b0);

        // 6: start held high; operands change every cycle
        d0 = n_done;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            a = a + 16'h0101; b = b ^ 16'h8421; cin = ~cin;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("s6_ndone", n_done - d0, 4);

        // WIDTH=4 instance: 7 + 7 + 1
        a4 = 4'h7; b4 = 4'h7; cin4 = 1'b1; start4 = 1'b1;
        @(negedge clk); #1;
        start4 = 1'b0;
        check("w4_busy", {31'd0, busy4}, 32'd1);
        check("w4_nodone", {31'd0, done4}, 32'd0);
        @(negedge clk);
        check("w4_done", {31'd0, done4}, 32'd1);
        check("w4_sum", {28'd0, sum4}, 32'hF);
        check("w4_cout", {31'd0, cout4}, 32'd0);
        check("w4_ovf", {31'd0, ovf4}, 32'd1);
        @(negedge clk); #1;
        check("w4_idle", {31'd0, done4 | busy4}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
